// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled UART byte receiver. The frame is 8N1 by default.
// Defining UART_PARITY_EN switches it to 8E1 and enables parity_err.
module uart_byte_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] color,
    output logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);
    // state     | meaning
    // IDLE      | line idle, waiting for a falling edge on synchronized rx
    // START     | confirming the start bit is still low at its midpoint
    // DATA      | sampling 8 data bits at mid-bit, LSB first
    // PARITY    | sampling the even-parity bit (UART_PARITY_EN only)
    // STOP      | checking the stop bit and issuing ready / frame_err / parity_err
    // WAIT_HIGH | after a framing error, holding off until the line returns high
    localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
`endif

    logic [2:0]       state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       sync_fill;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tick;
    logic             start_edge;
    logic             mid_bit;
`ifdef UART_PARITY_EN
    logic             par_bit;
`endif

    // rx_prev only holds real line samples once the synchronizer has flushed its
    // reset value, so a line already low at reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            sync_fill <= 2'b00;
            rx_prev   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rx_prev   <= sync_fill[1] & rx_sync;
        end
    end

    assign start_edge = (state == S_IDLE) && rx_prev && !rx_sync;
    assign tick       = (div_cnt == DIV_LAST);
    assign mid_bit    = tick && ((state == S_START) ? (tick_cnt == 4'd7) : (tick_cnt == 4'd15));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifndef UART_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            color     <= 8'h00;
            ready     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (start_edge) begin
                tick_cnt <= 4'd0;
            end else if (tick) begin
                tick_cnt <= mid_bit ? 4'd0 : tick_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state   <= S_START;
                        bit_cnt <= 3'd0;
                    end
                end
                S_START: begin
                    if (mid_bit) begin
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid_bit) begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (mid_bit) begin
                        par_bit <= rx_sync;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                    if (mid_bit) begin
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
`ifdef UART_PARITY_EN
                        else if (par_bit != ^shreg) begin
                            parity_err <= 1'b1;
                            state      <= S_IDLE;
                        end
`endif
                        else begin
                            ready <= 1'b1;
                            color <= shreg;
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx. Frames are serialized from plain bit lists, and a negedge monitor logs strobes.
// Parity scenarios are included when UART_PARITY_EN is defined.
module tb_uart_byte_rx;
    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 115200;
    localparam int DIV      = 54;
    localparam int BIT_CLK  = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS    = 11;
    localparam int LAT_HALF_BITS = 21;
`else
    localparam int FRAME_BITS    = 10;
    localparam int LAT_HALF_BITS = 19;
`endif
    localparam int EXP_LAT   = LAT_HALF_BITS * BIT_CLK / 2;
    localparam int LAT_TOL   = DIV + 3;
    localparam int FRAME_CLK = FRAME_BITS * BIT_CLK;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] color;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;
    int excl_viol  = 0;
    int color_viol = 0;
    logic [7:0] last_color  = 8'h00;
    logic [7:0] model_color = 8'h00;
    logic [7:0] rdy_col[$];
    int         rdy_cyc[$];
`ifdef UART_PARITY_EN
    logic flip_par = 1'b0;
`endif

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .reset(reset), .rx(rx), .color(color), .ready(ready),
        .busy(busy), .frame_err(frame_err), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            last_color = color;
        end else begin
            if (ready) begin
                rdy_col.push_back(color);
                rdy_cyc.push_back(cyc);
            end
            if (frame_err) fe_cnt++;
            if (parity_err) pe_cnt++;
            if ((ready && frame_err) || (ready && parity_err) || (frame_err && parity_err)) excl_viol++;
            if (color !== last_color && !ready) color_viol++;
            last_color = color;
        end
    end

    // Must be called right after a negedge; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ flip_par;
        repeat (BIT_CLK) @(negedge clk);
`endif
        rx = stop;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic expect_good(input string name, input int n0, input logic [7:0] b, input int sc);
        int lat;
        checks++;
        if (rdy_col.size() != n0 + 1) begin
            failures++;
            $display("FAIL %s_ready_count got=%0d exp=%0d", name, rdy_col.size() - n0, 1);
        end else begin
            checks++;
            if (rdy_col[n0] !== b) begin
                failures++;
                $display("FAIL %s_color got=%h exp=%h", name, rdy_col[n0], b);
            end
            lat = rdy_cyc[n0] - sc;
            checks++;
            if (lat < EXP_LAT - LAT_TOL || lat > EXP_LAT + LAT_TOL) begin
                failures++;
                $display("FAIL %s_latency got=%0d exp=%0d+/-%0d", name, lat, EXP_LAT, LAT_TOL);
            end
        end
        model_color = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (color !== 8'h00) begin failures++; $display("FAIL reset_color got=%h exp=%h", color, 8'h00); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int n0, fe0, sc;
        n0 = rdy_col.size();
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, sc);
        repeat (20) @(negedge clk);
        expect_good("single", n0, 8'hA5, sc);
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL single_frame_err got=%0d exp=%0d", fe_cnt - fe0, 0); end
        checks++; if (color !== 8'hA5) begin failures++; $display("FAIL single_color_hold got=%h exp=%h", color, 8'hA5); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int n0, sc;
        int gap;
        bytes[0] = 8'hFF; bytes[1] = 8'h00; bytes[2] = 8'h3C;
        n0 = rdy_col.size();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, sc);
        repeat (20) @(negedge clk);
        checks++;
        if (rdy_col.size() != n0 + 3) begin
            failures++;
            $display("FAIL b2b_ready_count got=%0d exp=%0d", rdy_col.size() - n0, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdy_col[n0 + i] !== bytes[i]) begin
                    failures++;
                    $display("FAIL b2b_color%0d got=%h exp=%h", i, rdy_col[n0 + i], bytes[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                gap = rdy_cyc[n0 + i] - rdy_cyc[n0 + i - 1];
                checks++;
                if (gap < FRAME_CLK - DIV || gap > FRAME_CLK + DIV) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, gap, FRAME_CLK);
                end
            end
        end
        model_color = bytes[2];
    endtask

    task automatic test_glitch();
        int n0, fe0, len;
        logic seen_busy;
        n0 = rdy_col.size();
        fe0 = fe_cnt;
        len = $urandom_range(150, 300);
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 440; i++) begin
            if (i == len) rx = 1'b1;
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", seen_busy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_clear got=%b exp=0 len=%0d", busy, len); end
        repeat (300) @(negedge clk);
        checks++; if (rdy_col.size() != n0) begin failures++; $display("FAIL glitch_ready got=%0d exp=0", rdy_col.size() - n0); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_err();
        int n0, fe0, sc;
        n0 = rdy_col.size();
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, sc);
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++; if (fe_cnt != fe0 + 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (rdy_col.size() != n0) begin failures++; $display("FAIL ferr_ready got=%0d exp=0", rdy_col.size() - n0); end
        checks++; if (color !== model_color) begin failures++; $display("FAIL ferr_color got=%h exp=%h", color, model_color); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_high_busy got=%b exp=1", busy); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_recover_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        int n0, fe0, pe0, sc;
        n0 = rdy_col.size();
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        fork
            send_frame(8'hC3, 1'b1, sc);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                #2 reset = 1'b1;
                #1;
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_async_busy got=%b exp=0", busy); end
                checks++; if (color !== 8'h00) begin failures++; $display("FAIL abort_color got=%h exp=%h", color, 8'h00); end
                repeat (20) @(negedge clk);
                reset = 1'b0;
            end
        join
        model_color = 8'h00;
        repeat (20) @(negedge clk);
        checks++;
        if (rdy_col.size() != n0 || fe_cnt != fe0 || pe_cnt != pe0) begin
            failures++;
            $display("FAIL abort_strobes got=%0d/%0d/%0d exp=0/0/0", rdy_col.size() - n0, fe_cnt - fe0, pe_cnt - pe0);
        end
        n0 = rdy_col.size();
        send_frame(8'h81, 1'b1, sc);
        repeat (20) @(negedge clk);
        expect_good("abort_next", n0, 8'h81, sc);
    endtask

    task automatic test_random();
        int n0, sc;
        logic [7:0] b;
        b = 8'($urandom);
        n0 = rdy_col.size();
        send_frame(b, 1'b1, sc);
        repeat (20) @(negedge clk);
        expect_good("random", n0, b, sc);
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int n0, pe0, sc;
        n0 = rdy_col.size();
        pe0 = pe_cnt;
        flip_par = 1'b1;
        send_frame(8'h07, 1'b1, sc);
        flip_par = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (pe_cnt != pe0 + 1) begin failures++; $display("FAIL parity_err_pulses got=%0d exp=1", pe_cnt - pe0); end
        checks++; if (rdy_col.size() != n0) begin failures++; $display("FAIL parity_bad_ready got=%0d exp=0", rdy_col.size() - n0); end
        checks++; if (color !== model_color) begin failures++; $display("FAIL parity_bad_color got=%h exp=%h", color, model_color); end
        n0 = rdy_col.size();
        send_frame(8'h07, 1'b1, sc);
        repeat (20) @(negedge clk);
        expect_good("parity_good", n0, 8'h07, sc);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
        test_random();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        checks++; if (excl_viol != 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", excl_viol); end
        checks++; if (color_viol != 0) begin failures++; $display("FAIL color_without_ready got=%0d exp=0", color_viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial line rate in bit/s.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 color  output  8  last correctly received byte; feeds the pixel assembler byte input.
REQ-007 ready  output  1  one-cycle strobe; color is valid when this is high.
REQ-008 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 frame_err  output  1  one-cycle strobe; stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle strobe for parity mismatch; tied 0 when UART_PARITY_EN is undefined.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all line timing is relative to the synchronized signal.
REQ-012 A tick generator SHALL pulse once every DIV = round(CLK_FREQ/(BAUD*16)) clocks (16x oversampling); the DIV counter SHALL be $clog2(DIV) bits wide, wrap to 0, and restart at 0 on every start-edge detection.
REQ-013 States: IDLE, START, DATA, PARITY (only with UART_PARITY_EN), STOP, WAIT_HIGH.
REQ-014 IDLE -> START on a high-to-low transition of synchronized rx.
REQ-015 START: at tick 8 (mid start bit) rx low -> DATA; rx high -> IDLE (glitch rejected, no strobe).
REQ-016 DATA: sample rx every 16 ticks at mid-bit, LSB first, into an 8-bit shift register; after bit 7 -> PARITY if enabled, else STOP.
REQ-017 STOP: at mid stop bit, rx high -> assert ready for exactly one clk, load color with the shift register, -> IDLE.
REQ-018 STOP with rx low -> assert frame_err for one clk, color unchanged, no ready, -> WAIT_HIGH; WAIT_HIGH -> IDLE once rx is high.
REQ-019 ready SHALL rise on the clk edge following the mid-stop-bit sample tick; latency from start edge to ready is 9.5 bit periods (10.5 with parity) +/- 1 tick + 3 clk.
REQ-020 color SHALL hold its value between ready strobes; it never changes without ready.
REQ-021 Back-to-back frames: return to IDLE at mid stop bit so a start edge arriving directly after the stop bit is detected with no lost frame.
REQ-022 ready, frame_err and parity_err SHALL be mutually exclusive in any cycle.
REQ-023 busy SHALL be high in every state except IDLE.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL force IDLE within the same cycle (asynchronous) and abort the frame with no strobes.
REQ-025 Reset values: color=8'h00, ready=0, busy=0, frame_err=0, parity_err=0, shift register=0, tick and bit counters=0, synchronizer flops=1.
REQ-026 After reset release, a frame whose start edge precedes release SHALL NOT be received; the next clean start edge SHALL be received.

Configuration
REQ-027 Macro UART_PARITY_EN: defined -> 8E1 frame; PARITY state samples the 9th bit; a mismatch with even parity over the 8 data bits asserts parity_err for one clk at mid stop bit instead of ready, color unchanged; stop-bit check still applies (frame_err takes priority).
REQ-028 UART_PARITY_EN undefined -> 8N1 frame; no PARITY state; parity_err constant 0.

Verification
REQ-029 CLK_FREQ=100e6, BAUD=115200 (DIV=54, 864 clk/bit): send 8'hA5 8N1 -> one ready pulse, color=8'hA5, frame_err=0.
REQ-030 Three back-to-back bytes 8'hFF, 8'h00, 8'h3C with no idle gap -> three ready pulses in order, color matching each, ~8640 clk apart.
REQ-031 Low glitch of 200 clk on idle rx -> no ready, no frame_err, busy returns 0 within 440 clk.
REQ-032 Send 8'h55 with stop bit held low -> frame_err one pulse, no ready, color keeps previous value; state stays WAIT_HIGH until rx returns high.
REQ-033 reset asserted during bit 4 of 8'hC3, released, then 8'h81 sent -> no strobe for the aborted frame, color=8'h81 after ready.
REQ-034 With UART_PARITY_EN: send 8'h07 with parity bit 0 -> parity_err pulse, no ready; with parity bit 1 -> ready, color=8'h07.
